// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

    localparam int REG_IDX_WIDTH = 5;

    // Field widths of the request record; they follow the controller's default parameters.
    localparam int WB_HART_WIDTH = 3;
    localparam int WB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [WB_HART_WIDTH-1:0] hart;
        logic [REG_IDX_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wb_state_e;

endpackage

// File: rtl/regfile_bypass.sv
// Write-to-read bypass for one register-file read port.
module regfile_bypass #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ram_we,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_din,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [DATA_WIDTH-1:0] rs_ram,
    output logic [DATA_WIDTH-1:0] rs_data
);

    always_comb begin
        rs_data = rs_ram;
        if (ram_we && (ram_addr == rs_addr)) rs_data = ram_din;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: registered write port, x0 suppression,
// two-port read bypass. Post-reset clear sweep is built when REGFILE_CLEAR_EN is defined.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int                 HART_WIDTH = 3,
    parameter int                 ADDR_WIDTH = HART_WIDTH + 5,
    parameter int                 SIZE       = 2 ** ADDR_WIDTH,
    parameter int                 DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [HART_WIDTH-1:0] wb_hart,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_ram,
    input  logic [DATA_WIDTH-1:0] rs2_ram,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  busy
);

    wb_req_t               req;
    logic                  accept;
    logic                  ram_we_d,   ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_d, ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_din_d,  ram_din_q;
    logic [DATA_WIDTH-1:0] rs1_byp, rs2_byp;

`ifdef REGFILE_CLEAR_EN
    wb_state_e             state_d,   state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_d, clr_cnt_q;
    logic                  busy_d,    busy_q;

    // busy lags the state by one cycle so it covers the last clear write.
    assign busy     = busy_q;
    assign wb_ready = ~busy_q;
`else
    assign busy     = 1'b0;
    assign wb_ready = 1'b1;
`endif

    always_comb begin
        req.hart   = wb_hart;
        req.rd     = wb_rd;
        req.data   = wb_data;
        accept     = wb_valid && wb_ready;
        ram_we_d   = accept && (req.rd != '0);
        ram_addr_d = accept ? {req.hart, req.rd} : ram_addr_q;
        ram_din_d  = accept ? req.data : ram_din_q;
`ifdef REGFILE_CLEAR_EN
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        busy_d     = (state_q == CLEAR);
        if (state_q == CLEAR) begin
            ram_we_d   = 1'b1;
            ram_addr_d = clr_cnt_q;
            ram_din_d  = INIT_VAL;
            if (clr_cnt_q == ADDR_WIDTH'(SIZE - 1)) state_d = RUN;
            else clr_cnt_d = clr_cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
`ifdef REGFILE_CLEAR_EN
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b1;
`endif
        end else begin
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
`ifdef REGFILE_CLEAR_EN
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            busy_q     <= busy_d;
`endif
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

    regfile_bypass #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_byp_rs1 (
        .ram_we  (ram_we_q),
        .ram_addr(ram_addr_q),
        .ram_din (ram_din_q),
        .rs_addr (rs1_addr),
        .rs_ram  (rs1_ram),
        .rs_data (rs1_byp)
    );

    regfile_bypass #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_byp_rs2 (
        .ram_we  (ram_we_q),
        .ram_addr(ram_addr_q),
        .ram_din (ram_din_q),
        .rs_addr (rs2_addr),
        .rs_ram  (rs2_ram),
        .rs_data (rs2_byp)
    );

    // RAM contents are not yet defined while the sweep runs.
    assign rs1_data = busy ? INIT_VAL : rs1_byp;
    assign rs2_data = busy ? INIT_VAL : rs2_byp;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a behavioural RAM model; covers both
// REGFILE_CLEAR_EN builds.
module tb_regfile_wb_ctrl;

    localparam int HW = 3;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [HW-1:0] wb_hart = '0;
    logic [4:0]    wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] rs1_addr = '0;
    logic [AW-1:0] rs2_addr = '0;
    logic [DW-1:0] rs1_ram, rs2_ram, rs1_data, rs2_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [256];

    always #5 clk = ~clk;

    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign rs1_ram = mem[rs1_addr];
    assign rs2_ram = mem[rs2_addr];

    regfile_wb_ctrl dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_hart(wb_hart), .wb_rd(wb_rd), .wb_data(wb_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_ram(rs1_ram), .rs2_ram(rs2_ram),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [HW-1:0] h, input logic [4:0] r,
                         input logic [DW-1:0] d);
        @(negedge clk);
        wb_valid = v; wb_hart = h; wb_rd = r; wb_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (!(ram_we === 1'b1 && ram_addr === AW'(i) && ram_din === '0 &&
                  busy === 1'b1 && wb_ready === 1'b0 && rs1_data === '0)) bad++;
        end
        chk({tag, "_bad_cycles"}, bad, 0);
        tick();
        chk({tag, "_we_after"}, {31'b0, ram_we}, 0);
        chk({tag, "_busy_after"}, {31'b0, busy}, 0);
        chk({tag, "_ready_after"}, {31'b0, wb_ready}, 1);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_we", {31'b0, ram_we}, 0);
        chk("rst_addr", {24'b0, ram_addr}, 0);
        chk("rst_din", ram_din, 0);
`ifdef REGFILE_CLEAR_EN
        chk("rst_busy", {31'b0, busy}, 1);
        chk("rst_ready", {31'b0, wb_ready}, 0);
        release_reset();
        for (int i = 0; i <= 100; i++) tick();
        chk("midclr_addr", {24'b0, ram_addr}, 100);
        #1 reset = 1'b1;
        #1;
        chk("midclr_rst_we", {31'b0, ram_we}, 0);
        chk("midclr_rst_addr", {24'b0, ram_addr}, 0);
        chk("midclr_rst_busy", {31'b0, busy}, 1);
        release_reset();
        sweep("sweep");
`else
        chk("rst_busy", {31'b0, busy}, 0);
        release_reset();
        tick();
        chk("run_ready", {31'b0, wb_ready}, 1);
        chk("run_we", {31'b0, ram_we}, 0);
`endif
        // basic write: hart 2, rd 5 -> address 0x45
        drive(1'b1, 3'd2, 5'd5, 32'hDEADBEEF);
        chk("basic_ready", {31'b0, wb_ready}, 1);
        tick();
        chk("basic_we", {31'b0, ram_we}, 1);
        chk("basic_addr", {24'b0, ram_addr}, 32'h45);
        chk("basic_din", ram_din, 32'hDEADBEEF);
        drive(1'b0, 3'd0, 5'd0, 32'h0);
        tick();
        chk("basic_we_off", {31'b0, ram_we}, 0);

        // x0 write is accepted but never reaches the RAM
        drive(1'b1, 3'd7, 5'd0, 32'h12345678);
        chk("x0_ready", {31'b0, wb_ready}, 1);
        tick();
        chk("x0_we", {31'b0, ram_we}, 0);
        drive(1'b0, 3'd0, 5'd0, 32'h0);
        tick();
        chk("x0_mem", mem[8'hE0], 0);

        // bypass: 0x22 <- 55AA55AA, then 0x21 <- CAFEF00D
        drive(1'b1, 3'd1, 5'd2, 32'h55AA55AA);
        tick();
        drive(1'b1, 3'd1, 5'd1, 32'hCAFEF00D);
        rs1_addr = 8'h21; rs2_addr = 8'h22;
        #1;
        chk("byp_rs2_in_wr", rs2_data, 32'h55AA55AA);
        chk("byp_rs1_old", rs1_data, 0);
        tick();
        chk("byp_rs1", rs1_data, 32'hCAFEF00D);
        chk("byp_rs2_ram", rs2_data, 32'h55AA55AA);
        chk("byp_rs1_ram_stale", rs1_ram, 0);
        drive(1'b0, 3'd0, 5'd0, 32'h0);
        tick();
        chk("byp_rs1_from_ram", rs1_data, 32'hCAFEF00D);

        // back-to-back writes to 0x10
        drive(1'b1, 3'd0, 5'd16, 32'h1);
        tick();
        chk("b2b_we1", {31'b0, ram_we}, 1);
        chk("b2b_addr1", {24'b0, ram_addr}, 32'h10);
        chk("b2b_din1", ram_din, 32'h1);
        drive(1'b1, 3'd0, 5'd16, 32'h2);
        tick();
        chk("b2b_we2", {31'b0, ram_we}, 1);
        chk("b2b_din2", ram_din, 32'h2);
        drive(1'b0, 3'd0, 5'd0, 32'h0);
        rs1_addr = 8'h10;
        tick();
        chk("b2b_we_off", {31'b0, ram_we}, 0);
        chk("b2b_final", rs1_data, 32'h2);

        // reset during a pending write drops it
        drive(1'b1, 3'd3, 5'd9, 32'hBAD0BAD0);
        tick();
        chk("midwr_we", {31'b0, ram_we}, 1);
        wb_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midwr_rst_we", {31'b0, ram_we}, 0);
        release_reset();
`ifdef REGFILE_CLEAR_EN
        sweep("sweep2");
`else
        tick();
`endif
        rs1_addr = 8'h69;
        #1;
        chk("midwr_dropped", rs1_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the per-hart register file. It sits directly upstream of the distributed-RAM register file banks and owns their write port. It accepts write-back requests from the pipeline and suppresses writes to x0. After reset it sweeps every RAM location to a known value. It also provides write-to-read bypass on two read ports, so a read issued in the same cycle as a RAM write returns the new data.

## Interface
Parameters:
- HART_WIDTH, 3, hart-id bits; number of harts is 2**HART_WIDTH
- ADDR_WIDTH, HART_WIDTH+5, RAM address = {hart_id, rd[4:0]}
- SIZE, 2**ADDR_WIDTH, RAM depth swept by clear
- DATA_WIDTH, 32, register width
- INIT_VAL, 0, value written by clear sweep

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- wb_valid  in  1  write-back request
- wb_ready  out  1  controller can accept request
- wb_hart  in  HART_WIDTH  issuing hart
- wb_rd  in  5  destination register
- wb_data  in  DATA_WIDTH  write data
- ram_we  out  1  RAM write enable (drives ena and wea)
- ram_addr  out  ADDR_WIDTH  RAM write address
- ram_din  out  DATA_WIDTH  RAM write data
- rs1_addr, rs2_addr  in  ADDR_WIDTH  read addresses, also driven to the two RAM copies
- rs1_ram, rs2_ram  in  DATA_WIDTH  combinational RAM read data
- rs1_data, rs2_data  out  DATA_WIDTH  bypassed read data
- busy  out  1  clear sweep in progress

## Operation
- State machine has two states:
  - CLEAR, entered on reset.
  - RUN.
- CLEAR:
  - Counter clr_cnt runs 0..SIZE-1, one location per cycle.
  - Outputs: ram_we=1, ram_addr=clr_cnt, ram_din=INIT_VAL.
  - Handshake: wb_ready=0, busy=1.
  - rs1_data and rs2_data are forced to INIT_VAL.
  - When clr_cnt==SIZE-1, the next state is RUN. The counter does not wrap.
- RUN:
  - wb_ready=1 every cycle; the output stage is one register that always drains.
  - A request is accepted when wb_valid && wb_ready.
  - The write-stage register captures {we, addr={wb_hart,wb_rd}, data}.
  - we=0 when wb_rd==0: the x0 write is accepted and discarded.
- Bypass:
  - rsN_data = ram_din when ram_we && ram_addr==rsN_addr; otherwise rsN_ram.
  - Applies to both ports independently.
- Back-to-back writes to the same address: the later one wins, one per cycle.
- Reset asserted mid-clear or mid-write:
  - Returns to CLEAR, clr_cnt=0.
  - Any pending write is dropped.
  - The sweep restarts from 0.

## Timing
- Reset values:
  - busy=1 and wb_ready=0 (with REGFILE_CLEAR_EN).
  - ram_we=0, ram_addr=0, ram_din=0.
  - The first clear write is asserted in the cycle after reset deasserts.
- Clear duration: exactly SIZE cycles of ram_we=1. busy falls, and wb_ready rises, in the cycle after the last clear write.
- Write latency: request accepted at edge N → ram_we high during cycle N+1 → RAM content updated at edge N+2.
- Bypass latency: zero cycles, combinational within cycle N+1.
- Reads in cycle N itself still see old RAM data. This is intended; the pipeline schedules hart reuse at least 2 cycles apart.
- No combinational path from wb_* to ram_* or wb_ready.

## Configuration
- REGFILE_CLEAR_EN defined:
  - CLEAR state and counter are present.
  - Behaviour is as above.
- REGFILE_CLEAR_EN undefined:
  - Reset goes directly to RUN; no counter.
  - busy is tied 0; wb_ready=1 from the first cycle after reset.
  - RAM content relies on its power-up initialisation to INIT_VAL.

## Structure
- Shared package holds:
  - typedef wb_req_t {hart, rd, data}
  - enum wb_state_e {CLEAR, RUN}
  - constant REG_IDX_WIDTH=5
- Bypass compare is one sub-module, regfile_bypass, instantiated twice: inputs ram_we, ram_addr, ram_din, rs_addr, rs_ram; output rs_data.
- RAM banks are instantiated by the parent, not inside this block.

## Test plan
- Clear sweep: release reset → ram_we=1 for exactly 256 cycles, ram_addr 0x00..0xFF, ram_din=0, then busy=0 and wb_ready=1.
- Basic write: hart 2, rd 5, data 0xDEADBEEF accepted at edge N → ram_we=1, ram_addr=0x45, ram_din=0xDEADBEEF in cycle N+1.
- x0 suppression: wb_rd=0, data 0x12345678, hart 7 → accepted (wb_ready=1), ram_we stays 0.
- Bypass: write 0xCAFEF00D to addr 0x21; in the write cycle rs1_addr=0x21, rs2_addr=0x22 → rs1_data=0xCAFEF00D, rs2_data=rs2_ram.
- Reset mid-clear: assert reset at clr_cnt=100 → outputs to reset values; after release the sweep restarts at 0 and takes 256 more cycles.
- Back-to-back: writes to 0x10 of 0x1 then 0x2 on consecutive cycles → two ram_we pulses in order; final RAM[0x10]=0x2.
